// File: rtl/if_btb_fetch_if.sv
// -----------------------------------------------------------------------------
// if_btb_fetch_if
// Bundle of the fetch-unit control, training and PC/prediction signals.
//   master : pipeline side (drives stall/halt/flush and BTB training,
//            observes the fetch PC and prediction)
//   slave  : the fetch unit itself
// Signals:
//   stall, halt      hold the fetch PC
//   flush, flush_pc  redirect from EX (overrides stall/halt)
//   upd_valid, upd_pc, upd_taken, upd_target   resolved branch outcome
//   cpc              current fetch PC (registered)
//   pred_taken       BTB prediction for cpc (combinational)
//   pred_target      predicted target for cpc, 0 when not taken
// -----------------------------------------------------------------------------
interface if_btb_fetch_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            halt;
  logic            flush;
  logic [XLEN-1:0] flush_pc;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic [XLEN-1:0] cpc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  modport master (
    output stall, halt, flush, flush_pc,
    output upd_valid, upd_pc, upd_taken, upd_target,
    input  cpc, pred_taken, pred_target
  );

  modport slave (
    input  stall, halt, flush, flush_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    output cpc, pred_taken, pred_target
  );
endinterface

// File: rtl/if_btb_fetch.sv
// -----------------------------------------------------------------------------
// if_btb_fetch
// Instruction-fetch PC register with a direct-mapped branch target buffer and
// 2-bit saturating direction counters.
//
// Next-PC priority: rst > flush > (stall|halt hold) > predicted target > +PC_STEP
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (clears PC and the whole BTB)
//   bus  if_btb_fetch_if.slave (control in, training in, cpc/prediction out)
//
// Build option:
//   IF_BTB_EN  defined   -> BTB, counters and training logic present
//              undefined -> no BTB; pred_taken/pred_target tied to 0 and the
//                           upd_* inputs are ignored
// -----------------------------------------------------------------------------
module if_btb_fetch #(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              PC_STEP   = 4
) (
  input logic              clk,
  input logic              rst,
  if_btb_fetch_if.slave    bus
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [XLEN-1:0] r_cpc;
  logic [XLEN-1:0] w_next_pc;
  logic            w_pred_taken;
  logic [XLEN-1:0] w_pred_target;

`ifdef IF_BTB_EN
  // NOTE: the BTB is built from flops rather than a RAM macro because reset
  // must invalidate every entry asynchronously in a single event.
  logic             r_valid  [BTB_DEPTH];
  logic [TAG_W-1:0] r_tag    [BTB_DEPTH];
  logic [XLEN-1:0]  r_target [BTB_DEPTH];
  logic [1:0]       r_ctr    [BTB_DEPTH];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic [3:0]       w_unused_bits;

  // Lookup on the current fetch PC (reads pre-edge contents).
  assign w_idx         = r_cpc[IDX_W+1:2];
  assign w_tag         = r_cpc[XLEN-1:IDX_W+2];
  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_pred_taken  = w_hit && r_ctr[w_idx][1];
  assign w_pred_target = w_pred_taken ? r_target[w_idx] : '0;

  assign w_upd_idx = bus.upd_pc[IDX_W+1:2];
  assign w_upd_tag = bus.upd_pc[XLEN-1:IDX_W+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // Word-alignment bits never take part in indexing or tagging.
  assign w_unused_bits = {r_cpc[1:0], bus.upd_pc[1:0]};

  // Training is independent of stall/halt/flush: every update is applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'd1;
      end
    end else if (bus.upd_valid) begin
      if (w_upd_hit) begin
        if (bus.upd_taken) begin
          r_target[w_upd_idx] <= bus.upd_target;
          if (r_ctr[w_upd_idx] != 2'd3)
            r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'd1;
        end else if (r_ctr[w_upd_idx] != 2'd0) begin
          r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'd1;
        end
      end else if (bus.upd_taken) begin
        // Allocate weakly taken, evicting whatever aliased into this slot.
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= bus.upd_target;
        r_ctr[w_upd_idx]    <= 2'd2;
      end
    end
  end
`else
  logic [2*XLEN+1:0] w_unused_bits;

  assign w_pred_taken  = 1'b0;
  assign w_pred_target = '0;
  assign w_unused_bits = {bus.upd_valid, bus.upd_taken, bus.upd_pc, bus.upd_target};
`endif

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next_pc = r_cpc + XLEN'(PC_STEP);
    if (bus.flush)
      w_next_pc = bus.flush_pc;
    else if (bus.stall || bus.halt)
      w_next_pc = r_cpc;
    else if (w_pred_taken)
      w_next_pc = w_pred_target;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cpc <= RESET_PC;
    else     r_cpc <= w_next_pc;
  end

  assign bus.cpc         = r_cpc;
  assign bus.pred_taken  = w_pred_taken;
  assign bus.pred_target = w_pred_target;

endmodule

// File: tb/tb_if_btb_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_btb_fetch
// Scoreboard bench for if_btb_fetch. The stimulus process drives one cycle of
// inputs on each falling edge, advances a behavioural model of the fetch unit
// and BTB, and queues the expected post-edge cpc/prediction. A monitor
// samples the DUT shortly after each rising edge and compares against the
// queue head. Directed scenarios come first, then randomized traffic with
// occasional asynchronous resets.
// -----------------------------------------------------------------------------
module tb_if_btb_fetch;

  localparam int          XLEN      = 32;
  localparam int          BTB_DEPTH = 16;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam int          N_RANDOM  = 3000;

  typedef struct {
    logic [31:0] cpc;
    logic        pt;
    logic [31:0] ptgt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_btb_fetch_if #(.XLEN(XLEN)) bus ();

  if_btb_fetch #(
    .XLEN(XLEN), .BTB_DEPTH(BTB_DEPTH), .RESET_PC(RESET_PC), .PC_STEP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_cpc;
  bit          m_valid [BTB_DEPTH];
  int unsigned m_tag   [BTB_DEPTH];
  logic [31:0] m_tgt   [BTB_DEPTH];
  int          m_ctr   [BTB_DEPTH];

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  function automatic int unsigned slot_of(input logic [31:0] pc);
    return (pc / 4) % BTB_DEPTH;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * BTB_DEPTH);
  endfunction

  function automatic exp_t predict(input logic [31:0] pc);
    exp_t e;
    int unsigned s;
    e.cpc  = pc;
    e.pt   = 1'b0;
    e.ptgt = 32'h0;
`ifdef IF_BTB_EN
    s = slot_of(pc);
    if (m_valid[s] && m_tag[s] == tag_of(pc) && m_ctr[s] >= 2) begin
      e.pt   = 1'b1;
      e.ptgt = m_tgt[s];
    end
`else
    s = 0;
`endif
    return e;
  endfunction

  function automatic void model_reset();
    m_cpc = RESET_PC;
    for (int i = 0; i < BTB_DEPTH; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_tgt[i]   = 32'h0;
      m_ctr[i]   = 1;
    end
  endfunction

  function automatic void model_train(input logic [31:0] pc, input logic taken,
                                      input logic [31:0] tgt);
`ifdef IF_BTB_EN
    int unsigned s;
    s = slot_of(pc);
    if (m_valid[s] && m_tag[s] == tag_of(pc)) begin
      if (taken) begin
        m_tgt[s] = tgt;
        m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
      end else begin
        m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
      end
    end else if (taken) begin
      m_valid[s] = 1;
      m_tag[s]   = tag_of(pc);
      m_tgt[s]   = tgt;
      m_ctr[s]   = 2;
    end
`endif
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h",
                  name, cyc, act, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("cpc", bus.cpc, e.cpc);
        check("pred_taken", {31'b0, bus.pred_taken}, {31'b0, e.pt});
        check("pred_target", bus.pred_target, e.ptgt);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_cycle(input logic s, input logic h, input logic f,
                             input logic [31:0] fpc, input logic uv,
                             input logic [31:0] upc, input logic ut,
                             input logic [31:0] utgt);
    exp_t cur;
    @(negedge clk);
    rst            = 1'b0;
    bus.stall      = s;
    bus.halt       = h;
    bus.flush      = f;
    bus.flush_pc   = fpc;
    bus.upd_valid  = uv;
    bus.upd_pc     = upc;
    bus.upd_taken  = ut;
    bus.upd_target = utgt;
    cur = predict(m_cpc);
    if (f)           m_cpc = fpc;
    else if (s || h) m_cpc = m_cpc;
    else if (cur.pt) m_cpc = cur.ptgt;
    else             m_cpc = m_cpc + 32'd4;
    if (uv) model_train(upc, ut, utgt);
    sb_q.push_back(predict(m_cpc));
  endtask

  task automatic idle();
    drive_cycle(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic redirect(input logic [31:0] pc);
    drive_cycle(0, 0, 1, pc, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic train(input logic [31:0] pc, input logic taken,
                       input logic [31:0] tgt);
    drive_cycle(1, 0, 0, 32'h0, 1, pc, taken, tgt);
  endtask

  // Reset asserted between edges with a pending update on the port: the
  // update must be discarded and the BTB cleared.
  task automatic do_reset();
    @(negedge clk);
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = m_cpc;
    bus.upd_taken  = 1'b1;
    bus.upd_target = 32'h0000_0300;
    #2;
    rst = 1'b1;
    model_reset();
    sb_q.push_back(predict(m_cpc));
  endtask

  function automatic logic [31:0] rnd_pc();
    return 32'($urandom_range(0, 255)) * 32'd4;
  endfunction

  initial begin : stimulus
    logic [31:0] fpc, upc;
    rst            = 1'b1;
    bus.stall      = 1'b0;
    bus.halt       = 1'b0;
    bus.flush      = 1'b0;
    bus.flush_pc   = 32'h0;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = 32'h0;
    bus.upd_taken  = 1'b0;
    bus.upd_target = 32'h0;
    model_reset();
    do_reset();

    // Sequential fetch after reset, then up to 0x10.
    repeat (4) idle();
    // Stall and halt hold; flush beats stall.
    drive_cycle(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    drive_cycle(0, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    drive_cycle(1, 1, 1, 32'h80, 0, 32'h0, 0, 32'h0);
    // Allocation and prediction.
    train(32'h20, 1, 32'h100);
    redirect(32'h20);
    idle();
    idle();
    // Hysteresis: down to 0, then saturate at 3 and one step back to 2.
    train(32'h20, 0, 32'h0);
    train(32'h20, 0, 32'h0);
    redirect(32'h20);
    idle();
    repeat (4) train(32'h20, 1, 32'h100);
    train(32'h20, 0, 32'h0);
    redirect(32'h20);
    idle();
    // Aliasing replaces the entry.
    train(32'h20 + 4 * BTB_DEPTH, 1, 32'h200);
    redirect(32'h20);
    idle();
    redirect(32'h20 + 4 * BTB_DEPTH);
    idle();
    // Same-cycle lookup and update on the current PC.
    redirect(32'h40);
    drive_cycle(0, 0, 0, 32'h0, 1, 32'h40, 1, 32'h180);
    redirect(32'h40);
    idle();
    // Wrap of the sequential add.
    redirect(32'hFFFF_FFFC);
    idle();
    idle();

    // Randomized traffic.
    for (int i = 0; i < N_RANDOM; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        fpc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : rnd_pc();
        upc = ($urandom_range(0, 1) == 0) ? m_cpc : rnd_pc();
        drive_cycle($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 6) == 0, fpc,
                    $urandom_range(0, 1) == 0, upc,
                    $urandom_range(0, 4) < 3, rnd_pc());
      end
    end

    @(posedge clk);
    #3;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
